// File: rtl/seg_scan_disp_pkg.sv
// Shared constants for the multiplexed 7-segment display: active-low segment
// codes {g,f,e,d,c,b,a}, the dp bit position and the digit slot numbering.
package seg_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int DP_BIT = 7;

   localparam logic [1:0] IDX_MIN_ONE  = 2'd0;
   localparam logic [1:0] IDX_MIN_TEN  = 2'd1;
   localparam logic [1:0] IDX_HOUR_ONE = 2'd2;
   localparam logic [1:0] IDX_HOUR_TEN = 2'd3;

   // Anything outside 0..9 shows a dash so a bad upstream count is visible.
   function automatic logic [6:0] seg_code(input logic [3:0] v);
      logic [6:0] c;
      case (v)
         4'd0:    c = SEG_0;
         4'd1:    c = SEG_1;
         4'd2:    c = SEG_2;
         4'd3:    c = SEG_3;
         4'd4:    c = SEG_4;
         4'd5:    c = SEG_5;
         4'd6:    c = SEG_6;
         4'd7:    c = SEG_7;
         4'd8:    c = SEG_8;
         4'd9:    c = SEG_9;
         default: c = SEG_DASH;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/seg_scan_disp_if.sv
// Digit buses from the HH:MM counter plus the segment/select lines to the
// display. There is no handshake: digits are level signals sampled once per frame.
interface seg_scan_disp_if;
   logic [2:0] hour_ten;
   logic [3:0] hour_one;
   logic [2:0] minute_ten;
   logic [3:0] minute_one;
   logic       set_mode;
   logic [3:0] blink_mask;
   logic [7:0] seg;
   logic [3:0] sel;

   modport master (
      output hour_ten, hour_one, minute_ten, minute_one, set_mode, blink_mask,
      input  seg, sel
   );

   modport slave (
      input  hour_ten, hour_one, minute_ten, minute_one, set_mode, blink_mask,
      output seg, sel
   );
endinterface

// File: rtl/seg_scan_disp_decode.sv
// BCD to active-low 7-segment decoder with a blank override.
module seg_decode
   import seg_disp_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   output logic [6:0] code
);

   always_comb begin
      code = SEG_BLANK;
      if (!blank) begin
         code = seg_code(value);
      end
   end

endmodule

// File: rtl/seg_scan_disp.sv
// 4-digit common-anode scan driver: snapshots the HH:MM digits once per frame,
// scans one digit per slot, blinks selected digits in set mode, drives the colon.
module seg_scan_disp
   import seg_disp_pkg::*;
#(
   parameter logic [25:0] SCAN_DIV       = 26'd49999,
   parameter logic [25:0] BLINK_DIV      = 26'd24999999,
   parameter bit          LZ_SUPPRESS    = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic            mclk,
   input  logic            rst,
   seg_scan_disp_if.slave  disp
);

   localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [3:0] SEL_OFF = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;

   logic [25:0]     cnt;
   logic [1:0]      idx;
   logic            scan_tick;
   logic [25:0]     blink_cnt;
   logic            blink_ph;
   logic [3:0][3:0] snap;

   logic [3:0]      digit_v;
   logic            blank;
   logic            dp_lit;
   logic [6:0]      code7;
   logic [7:0]      seg_nxt;
   logic [3:0]      sel_nxt;

   assign scan_tick = (cnt == SCAN_DIV);

   always_ff @(posedge mclk) begin
      if (rst) begin
         cnt <= '0;
         idx <= IDX_MIN_ONE;
      end else if (scan_tick) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 26'd1;
      end
   end

   // Capture at the end of the last slot so a whole frame shows one coherent time.
   always_ff @(posedge mclk) begin
      if (rst) begin
         snap <= '0;
      end else if (scan_tick && idx == IDX_HOUR_TEN) begin
         snap[IDX_MIN_ONE]  <= disp.minute_one;
         snap[IDX_MIN_TEN]  <= {1'b0, disp.minute_ten};
         snap[IDX_HOUR_ONE] <= disp.hour_one;
         snap[IDX_HOUR_TEN] <= {1'b0, disp.hour_ten};
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (blink_cnt == BLINK_DIV) begin
         blink_cnt <= '0;
         blink_ph  <= ~blink_ph;
      end else begin
         blink_cnt <= blink_cnt + 26'd1;
      end
   end

   always_comb begin
      digit_v = snap[idx];
      blank   = (disp.set_mode && disp.blink_mask[idx] && !blink_ph) ||
                (LZ_SUPPRESS && idx == IDX_HOUR_TEN && digit_v == 4'd0);
      // Colon rides on the hour-units dp; steady while the time is being set.
      dp_lit  = (idx == IDX_HOUR_ONE) && (disp.set_mode || blink_ph);
      seg_nxt = {~dp_lit, code7};
      sel_nxt = ~(4'b0001 << idx);
   end

   seg_decode u_decode (
      .value (digit_v),
      .blank (blank),
      .code  (code7)
   );

   always_ff @(posedge mclk) begin
      if (rst) begin
         disp.seg <= SEG_OFF;
         disp.sel <= SEL_OFF;
      end else if (SEG_ACTIVE_LOW) begin
         disp.seg <= seg_nxt;
         disp.sel <= sel_nxt;
      end else begin
         disp.seg <= ~seg_nxt;
         disp.sel <= ~sel_nxt;
      end
   end

endmodule

// File: doc/seg_scan_disp.md
Name: seg_scan_disp

Overview:
- Time-multiplexed 4-digit common-anode 7-segment driver.
- Sits directly downstream of the HH:MM digit counter and consumes its four BCD digit buses.
- Scans one digit at a time, decodes BCD to segments and drives the colon as a decimal point.
- In set mode, blinks the digits selected for adjustment.

Parameters:
- SCAN_DIV, 26'd49999: mclk cycles per digit slot minus 1; 1 kHz slot rate at 50 MHz.
- BLINK_DIV, 26'd24999999: mclk cycles per blink half-period minus 1; 0.5 s.
- LZ_SUPPRESS, 1: 1 = blank hour_ten when it is 0.
- SEG_ACTIVE_LOW, 1: 1 = seg and sel are active-low; 0 = both are inverted.

Ports:
- mclk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- hour_ten, input, 3: hour tens digit.
- hour_one, input, 4: hour units digit.
- minute_ten, input, 3: minute tens digit.
- minute_one, input, 4: minute units digit.
- set_mode, input, 1: 1 = time-setting mode (blink enabled, colon steady).
- blink_mask, input, 4: per-digit blink enable; bit i maps to digit index i.
- seg, output, 8: {dp,g,f,e,d,c,b,a}.
- sel, output, 4: digit enable; bit i drives digit index i.

Behaviour:
- Interface decision: one clock (mclk); reset is synchronous and active-high (rst). All state updates only on posedge mclk.
- Digit index mapping: 0 = minute_one (rightmost), 1 = minute_ten, 2 = hour_one, 3 = hour_ten.
- Scan counter cnt (26 bit):
  - counts 0..SCAN_DIV, then wraps to 0;
  - scan_tick = (cnt == SCAN_DIV);
  - idx (2 bit) increments on scan_tick, wrapping 3 -> 0.
- Snapshot:
  - On scan_tick with idx == 3, all four input digits are captured into snapshot registers.
  - The display only ever shows snapshot values, so there is no tearing within a frame.
  - Inputs that change mid-frame take effect at the next frame.
- Blink counter:
  - counts 0..BLINK_DIV; at BLINK_DIV it wraps and toggles blink_ph.
  - Free-running, independent of scan.
- Digit value v = snapshot[idx], zero-extended to 4 bits.
- Decode, active-low form:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90.
  - Any v > 9 = BF (dash, g segment only).
  - Blank = FF.
- Blank conditions (either one blanks the digit):
  - set_mode && blink_mask[idx] && !blink_ph;
  - LZ_SUPPRESS && idx == 3 && v == 0.
- Colon (dp segment):
  - Lit only when idx == 2.
  - Lit condition: blink_ph in run mode; always lit in set mode.
  - dp is independent of digit blanking.
- sel is one-hot-low on idx (e.g. idx 0 -> 4'b1110).
- Outputs seg and sel are registered: they reflect the new idx exactly 1 mclk after the idx update.
- SEG_ACTIVE_LOW = 0: seg and sel are bitwise inverted at the output register.
- Reset values:
  - cnt = 0, idx = 0, blink_ph = 0, snapshots = 0;
  - sel = all off (4'b1111 in active-low form), seg = all off (8'hFF in active-low form).
  - From the first post-reset cycle, sel = 1110 and seg shows snapshot 0 (C0).
  - Until the first frame wrap, the display shows 00:00, with hour_ten blank if LZ_SUPPRESS.
- Reset mid-scan: all counters restart immediately. No partial slot, no glitch beyond a one-cycle all-off.
- set_mode changes: take effect at the next output register update; the blink phase is not reset.

Decomposition:
- Package seg_disp_pkg holds:
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (active-low);
  - DP bit index 7;
  - digit index constants IDX_MIN_ONE..IDX_HOUR_TEN.
- One combinational sub-module, seg_decode: 4-bit value plus blank flag in, 7-bit segment code out.
- Counters, snapshot, blink logic and output registers live in the top module.

Test Plan (SCAN_DIV = 3, BLINK_DIV = 15, SEG_ACTIVE_LOW = 1):
1. rst held 2 cycles with inputs 1,2,3,4 -> during reset seg = FF, sel = 1111. After release:
   - sel sequence 1110, 1101, 1011, 0111, each held 4 cycles;
   - first frame shows C0 on minute_one; after the first wrap seg = 99 (4) on sel 1110.
2. Inputs 1:2:3:4 steady over 2 frames, set_mode = 0 -> frame 2 (digits 0..3):
   - seg = 99, B0, A4 with dp per blink_ph, F9;
   - colon toggles every 16 cycles.
3. hour_ten = 0, LZ_SUPPRESS = 1 -> seg = FF on sel 0111. With LZ_SUPPRESS = 0 -> C0.
4. set_mode = 1, blink_mask = 0011 -> seg = FF on digits 0/1 while blink_ph = 0, normal codes while blink_ph = 1; colon steadily lit (dp = 0) on digit 2.
5. minute_one forced to 4'd12 -> seg = BF on digit 0. Change minute_one at idx = 1 -> new value shows only after the next wrap.
6. Assert rst mid-slot at idx = 2 -> next cycle sel = 1111, seg = FF, then the scan restarts at idx 0 with cnt = 0.
